// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// default reset PC and J-type field layout.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int J_INDEX_MSB = 25;
  localparam int J_INDEX_LSB = 0;
  localparam int J_INDEX_W   = J_INDEX_MSB - J_INDEX_LSB + 1;

  // Pseudo-direct jump target: region bits of PC+4 glued to the word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                              input logic [J_INDEX_W-1:0] index);
    return {pc_plus_4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_next_pc_logic.sv
// Combinational next-PC selection from execute's redirect results,
// plus a word-alignment check on the chosen target.
module next_pc_logic
  import ifetch_unit_pkg::*;
(
  input  logic [31:0]          i_pc_plus_4,
  input  logic [J_INDEX_W-1:0] i_instr_index,
  input  logic                 i_branch,
  input  logic                 i_nbranch,
  input  logic                 i_jmp,
  input  logic                 i_jal,
  input  logic                 i_jr,
  input  logic                 i_zero,
  input  logic [31:0]          i_addr_result,
  input  logic [31:0]          i_read_data_1,
  output logic [31:0]          o_next_pc,
  output logic                 o_misaligned
);

  logic w_take_branch;

  assign w_take_branch = (i_branch & i_zero) | (i_nbranch & ~i_zero);

  // Priority mux: jr beats jumps beats taken branches beats sequential.
  always_comb begin
    o_next_pc = i_pc_plus_4;
    if (i_jr) begin
      o_next_pc = i_read_data_1;
    end else if (i_jmp | i_jal) begin
      o_next_pc = jump_target(i_pc_plus_4, i_instr_index);
    end else if (w_take_branch) begin
      o_next_pc = i_addr_result;
    end else begin
      o_next_pc = i_pc_plus_4;
    end
  end

  assign o_misaligned = (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, req/rvalid memory fetch, valid/ready
// hand-off to execute, redirect on accept and sticky misalignment fault.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] Instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] PC_plus_4,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        Zero,
  input  logic [31:0] Addr_result,
  input  logic [31:0] Read_data_1,
  output logic [31:0] link_addr,
  output logic        fetch_fault,
  output logic [31:0] inst_count
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_link;
  logic [31:0]  r_count;
  logic         r_fault;
  logic [31:0]  w_pc_plus_4;
  logic [31:0]  w_next_pc;
  logic         w_misaligned;
  logic         w_accept;

  assign w_pc_plus_4 = r_pc + 32'd4;
  assign w_accept    = (r_state == ST_HOLD) & inst_ready;

  next_pc_logic u_next_pc (
    .i_pc_plus_4   (w_pc_plus_4),
    .i_instr_index (r_instr[J_INDEX_MSB:J_INDEX_LSB]),
    .i_branch      (Branch),
    .i_nbranch     (nBranch),
    .i_jmp         (Jmp),
    .i_jal         (Jal),
    .i_jr          (Jr),
    .i_zero        (Zero),
    .i_addr_result (Addr_result),
    .i_read_data_1 (Read_data_1),
    .o_next_pc     (w_next_pc),
    .o_misaligned  (w_misaligned)
  );

  // Next-state decode for the fetch FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = ST_REQ;
      ST_REQ:   w_state_next = imem_rvalid ? ST_HOLD : ST_REQ;
      ST_HOLD: begin
        if (w_accept) begin
          w_state_next = w_misaligned ? ST_FAULT : ST_REQ;
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State, PC, instruction, link, counter and fault registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_link  <= 32'h0000_0000;
      r_count <= 32'h0000_0000;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_REQ) && imem_rvalid) begin
        r_instr <= imem_rdata;
      end
      if (w_accept) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 32'd1;
        if (Jal) begin
          r_link <= w_pc_plus_4;
        end
        if (w_misaligned) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_pc;
  assign inst_valid  = (r_state == ST_HOLD);
  assign Instruction = r_instr;
  assign PC_plus_4   = w_pc_plus_4;
  assign link_addr   = r_link;
  assign fetch_fault = r_fault;
  assign inst_count  = r_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: sequential fetch, stalls,
// branch/jump redirects, link capture, PC wrap, fault and reset behaviour.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] Instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] PC_plus_4;
  logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
  logic [31:0] Addr_result;
  logic [31:0] Read_data_1;
  logic [31:0] link_addr;
  logic        fetch_fault;
  logic [31:0] inst_count;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .Instruction (Instruction),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .PC_plus_4   (PC_plus_4),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .Zero        (Zero),
    .Addr_result (Addr_result),
    .Read_data_1 (Read_data_1),
    .link_addr   (link_addr),
    .fetch_fault (fetch_fault),
    .inst_count  (inst_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait for a request, check its address, answer after lat cycles.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int lat);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check_eq("req_seen", {31'd0, imem_req}, 32'd1);
    check_eq("imem_addr", imem_addr, exp_addr);
    for (int i = 0; i < lat; i++) begin
      @(negedge clock);
      check_eq("addr_stable", imem_addr, exp_addr);
      check_eq("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clock);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    check_eq("inst_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("instruction", Instruction, data);
    check_eq("pc_plus_4", PC_plus_4, exp_addr + 32'd4);
  endtask

  task automatic accept(input logic jr_i, input logic jmp_i, input logic jal_i,
                        input logic br_i, input logic nbr_i, input logic zero_i,
                        input logic [31:0] addr_i, input logic [31:0] rd1_i);
    Jr = jr_i; Jmp = jmp_i; Jal = jal_i; Branch = br_i; nBranch = nbr_i; Zero = zero_i;
    Addr_result = addr_i; Read_data_1 = rd1_i;
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    Jr = 1'b0; Jmp = 1'b0; Jal = 1'b0; Branch = 1'b0; nBranch = 1'b0; Zero = 1'b0;
    Addr_result = 32'h0000_0000; Read_data_1 = 32'h0000_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_rdata = 32'h0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jr = 1'b0; Zero = 1'b0;
    Addr_result = 32'h0; Read_data_1 = 32'h0;
    repeat (2) @(negedge clock);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_instr", Instruction, 32'h0);
    check_eq("rst_pc4", PC_plus_4, 32'h4);
    check_eq("rst_link", link_addr, 32'h0);
    check_eq("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check_eq("rst_count", inst_count, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("first_req", {31'd0, imem_req}, 32'd1);

    // Zero-wait sequential stream, one instruction per two cycles.
    for (int k = 0; k < 4; k++) begin
      fetch(32'(k * 4), 32'h2000_0000 + 32'(k), 0);
      accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("req_next_cycle", {31'd0, imem_req}, 32'd1);
    end
    check_eq("count_4", inst_count, 32'd4);

    // Slow memory, then a stall with stray redirects that must be ignored.
    fetch(32'h10, 32'h2408_0005, 3);
    Jr = 1'b1; Read_data_1 = 32'h300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_eq("stall_valid", {31'd0, inst_valid}, 32'd1);
      check_eq("stall_noreq", {31'd0, imem_req}, 32'd0);
      check_eq("stall_instr", Instruction, 32'h2408_0005);
      check_eq("stall_addr", imem_addr, 32'h10);
    end
    accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // J to 0x40, then branch taken / not taken, nBranch both ways.
    fetch(32'h14, 32'h0800_0010, 0);
    accept(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h40, 32'h1000_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    fetch(32'h100, 32'h0, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
    fetch(32'h40, 32'h1000_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    fetch(32'h44, 32'h1400_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    fetch(32'h200, 32'h1400_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0);
    fetch(32'h204, 32'h0, 0);

    // Jal link capture, then Jr winning over Jmp.
    accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1000_0010);
    fetch(32'h1000_0010, 32'h0C00_0040, 0);
    accept(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("jal_link", link_addr, 32'h1000_0014);
    fetch(32'h1000_0100, 32'h0, 0);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200);
    fetch(32'h200, 32'h0, 0);

    // Sequential wrap at the top of the address space.
    accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("wrap_nofault", {31'd0, fetch_fault}, 32'd0);
    fetch(32'h0, 32'h0, 0);

    // Misaligned jr target faults and stops fetching until reset.
    accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h202);
    check_eq("fault_set", {31'd0, fetch_fault}, 32'd1);
    check_eq("fault_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("fault_pc", imem_addr, 32'h202);
    check_eq("fault_count", inst_count, 32'd17);
    check_eq("fault_link", link_addr, 32'h1000_0014);
    for (int i = 0; i < 3; i++) begin
      check_eq("fault_noreq", {31'd0, imem_req}, 32'd0);
      @(negedge clock);
    end
    check_eq("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    check_eq("count_cleared", inst_count, 32'd0);
    reset = 1'b0;
    fetch(32'h0, 32'h1111_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h4, 32'h1111_0004, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset during REQ; a late rvalid must not produce an instruction.
    check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_drops_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clock);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check_eq("late_rvalid_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("late_rvalid_instr", Instruction, 32'h0);
    check_eq("late_rvalid_addr", imem_addr, 32'h0);
    @(negedge clock);
    check_eq("late_rvalid_valid2", {31'd0, inst_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the MIPS-style CPU, directly upstream of the execute/ALU stage. Holds the PC and fetches from a variable-latency instruction memory over a req/rvalid handshake. Presents one instruction at a time with a valid/ready handshake, and supplies PC_plus_4 to execute. On acceptance it computes the next PC from execute's branch/jump results (Addr_result, Zero, Jr, Read_data_1).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request; held until imem_rvalid
- imem_addr  out  32  word-aligned fetch address (= PC), stable while imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- imem_rvalid  in  1  read data valid; ignored outside REQ
- Instruction  out  32  registered current instruction
- inst_valid  out  1  Instruction/PC_plus_4 valid
- inst_ready  in  1  downstream accepts and supplies redirect inputs this cycle
- PC_plus_4  out  32  PC+4 of the presented instruction (wraps mod 2^32)
- Branch, nBranch, Jmp, Jal, Jr  in  1 each  control decode of the presented instruction
- Zero  in  1  ALU zero flag
- Addr_result  in  32  branch target from ALU
- Read_data_1  in  32  jr target
- link_addr  out  32  registered PC_plus_4 captured on accepting a Jal
- fetch_fault  out  1  sticky: misaligned next PC computed
- inst_count  out  32  retired (accepted) instruction counter, wraps

## Operation
- States: IDLE, REQ, HOLD, FAULT. Encodings live in the shared header.
- IDLE: entered on reset. Goes to REQ after one cycle.
- REQ: imem_req=1, imem_addr=PC.
  - On imem_rvalid: Instruction <= imem_rdata, go to HOLD.
- HOLD: inst_valid=1, and Instruction is held.
  - On inst_valid & inst_ready (accept): PC <= next_pc, inst_count++, and if Jal then link_addr <= PC_plus_4.
  - After accept, go to REQ, or to FAULT if next_pc[1:0]!=0.
- next_pc priority:
  1. Jr → Read_data_1
  2. Jmp|Jal → {PC_plus_4[31:28], Instruction[25:0], 2'b00}
  3. (Branch&Zero)|(nBranch&~Zero) → Addr_result
  4. otherwise PC_plus_4
- Multiple redirect controls asserted together: the priority above applies, no error.
- FAULT: fetch_fault=1, imem_req=0, inst_valid=0. PC holds the faulting target. Exit only by reset.
- PC 32'hFFFF_FFFC sequential → next PC 0; no fault.
- Redirect inputs are sampled only on the accept cycle and ignored otherwise.

## Timing
- Reset values:
  - PC=RESET_PC, state=IDLE.
  - imem_req=0, Instruction=0, inst_valid=0, PC_plus_4=RESET_PC+4.
  - link_addr=0, fetch_fault=0, inst_count=0.
- Reset during REQ: the request drops the next cycle. An imem_rvalid arriving after reset is ignored, since the state is IDLE.
- First imem_req: first cycle after reset deasserts, plus one (IDLE cycle).
- imem_rvalid may arrive in the same cycle as imem_req (zero wait). inst_valid rises the following cycle.
- Accept in cycle N → imem_req with the new address in cycle N+1.
- Minimum throughput: one instruction per 2 cycles with a zero-wait memory and inst_ready tied high.
- inst_ready low while HOLD: all outputs stable, no memory activity.
- PC_plus_4 is combinational from PC (PC+4, 32-bit truncation).

## Structure
- Shared header definitions.v holds:
  - FSM state encodings (2-bit)
  - default RESET_PC
  - J-type field positions
- One combinational sub-module next_pc_logic: inputs are PC_plus_4, Instruction[25:0] and the redirect controls/targets; outputs are next_pc and misaligned.
- The FSM, PC, link and counter registers stay in ifetch_unit.

## Test plan
- Reset, zero-wait memory, inst_ready=1, no redirects: imem_addr sequence 0,4,8,C. inst_count=4 after 4 accepts. imem_req first high one cycle after reset release.
- Memory with 3-cycle latency and inst_ready held low for 5 cycles in HOLD: imem_addr stable during the wait. Instruction stable and no imem_req while stalled.
- Instruction at PC=0x40, Branch=1, Zero=1, Addr_result=0x100 → next imem_addr=0x100. Repeat with Zero=0 → 0x44. nBranch inverse.
- Jal at PC=0x1000_0010 with Instruction[25:0]=0x0000040 → imem_addr=0x1000_0100, link_addr=0x1000_0014. Jr with Read_data_1=0x200 and Jmp both high → 0x200.
- Jr with Read_data_1=0x202 → fetch_fault=1 next cycle, no further imem_req. Reset clears it and fetch resumes at RESET_PC.
- PC=0xFFFF_FFFC sequential accept → imem_addr=0. Reset asserted mid-REQ with late imem_rvalid → inst_valid stays 0.
